// File: rtl/spi_to_nitta_assembler_if.sv
// Chunk-in / word-out bus between the SPI slave driver, the assembler and the NITTA consumer.
// The overflow flag exists only when SPI_ASSEMBLER_OVERFLOW_EN is defined.
interface spi_to_nitta_assembler_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int SPI_DATA_WIDTH = 8
);
   logic                      spi_ready;
   logic [SPI_DATA_WIDTH-1:0] from_spi;
   logic                      nitta_ack;
   logic [DATA_WIDTH-1:0]     to_nitta;
   logic                      word_valid;
   logic                      busy;
`ifdef SPI_ASSEMBLER_OVERFLOW_EN
   logic                      overflow;

   modport slave  (input spi_ready, from_spi, nitta_ack,
                   output to_nitta, word_valid, busy, overflow);
   modport master (output spi_ready, from_spi, nitta_ack,
                   input to_nitta, word_valid, busy, overflow);
`else
   modport slave  (input spi_ready, from_spi, nitta_ack,
                   output to_nitta, word_valid, busy);
   modport master (output spi_ready, from_spi, nitta_ack,
                   input to_nitta, word_valid, busy);
`endif
endinterface

// File: rtl/spi_to_nitta_assembler.sv
// Assembles SPI chunks first-most-significant into NITTA words; word appears 1 cycle after the final strobe.
// No back-pressure toward SPI (every strobe accepted); SPI_ASSEMBLER_OVERFLOW_EN adds a sticky overwrite flag.
module spi_to_nitta_assembler #(
   parameter int DATA_WIDTH     = 32,
   parameter int SPI_DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   spi_to_nitta_assembler_if.slave bus
);
   localparam int CHUNKS = DATA_WIDTH / SPI_DATA_WIDTH;
   localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] word_next;
   logic                  last;
   logic                  complete;

   assign last     = (cnt == CNT_W'(CHUNKS - 1));
   assign complete = bus.spi_ready && last;
   assign bus.busy = (cnt != '0);

   generate
      if (CHUNKS == 1) begin : g_single
         assign word_next = bus.from_spi;
      end else begin : g_multi
         // Only the chunks before the last one need storing; the last arrives live.
         logic [DATA_WIDTH-SPI_DATA_WIDTH-1:0] shift;

         assign word_next = {shift, bus.from_spi};

         always_ff @(posedge clk) begin
            if (rst) begin
               shift <= '0;
            end else if (bus.spi_ready && !last) begin
               shift <= word_next[DATA_WIDTH-SPI_DATA_WIDTH-1:0];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         bus.to_nitta   <= '0;
         bus.word_valid <= 1'b0;
      end else begin
         if (bus.spi_ready) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
         end
         // A completing strobe wins over ack: the fresh word is what must be held valid.
         if (complete) begin
            bus.to_nitta   <= word_next;
            bus.word_valid <= 1'b1;
         end else if (bus.nitta_ack) begin
            bus.word_valid <= 1'b0;
         end
      end
   end

`ifdef SPI_ASSEMBLER_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.overflow <= 1'b0;
      end else if (complete && bus.word_valid && !bus.nitta_ack) begin
         bus.overflow <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_spi_to_nitta_assembler.sv
// Drives a 32-bit and a 16-bit assembler with directed chunk sequences and checks them every cycle
// against a chunk-list model, plus literal expectations taken from the worked examples.
module tb_spi_to_nitta_assembler;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_to_nitta_assembler_if #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8)) b32 ();
   spi_to_nitta_assembler_if #(.DATA_WIDTH(16), .SPI_DATA_WIDTH(8)) b16 ();

   spi_to_nitta_assembler #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8)) dut32 (
      .clk(clk), .rst(rst), .bus(b32.slave));
   spi_to_nitta_assembler #(.DATA_WIDTH(16), .SPI_DATA_WIDTH(8)) dut16 (
      .clk(clk), .rst(rst), .bus(b16.slave));

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: per DUT, a list of chunks received since the last word boundary.
   logic [7:0]  s_dat [2];
   logic        s_rdy [2];
   logic        s_ack [2];
   logic [7:0]  mq [2][4];
   int          mn [2];
   logic [31:0] mw [2];
   bit          mv [2];
   bit          mo [2];
   logic [31:0] m_w;
   bit          m_done;

   assign s_rdy[0] = b32.spi_ready;
   assign s_dat[0] = b32.from_spi;
   assign s_ack[0] = b32.nitta_ack;
   assign s_rdy[1] = b16.spi_ready;
   assign s_dat[1] = b16.from_spi;
   assign s_ack[1] = b16.nitta_ack;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int nch;
         nch = (d == 0) ? 4 : 2;
         if (rst) begin
            mn[d] = 0; mw[d] = '0; mv[d] = 1'b0; mo[d] = 1'b0;
         end else begin
            m_done = 1'b0;
            m_w    = '0;
            if (s_rdy[d]) begin
               mq[d][mn[d]] = s_dat[d];
               mn[d]++;
               if (mn[d] == nch) begin
                  for (int k = 0; k < nch; k++) m_w = (m_w << 8) | {24'h0, mq[d][k]};
                  mn[d]  = 0;
                  m_done = 1'b1;
               end
            end
            if (m_done) begin
               if (mv[d] && !s_ack[d]) mo[d] = 1'b1;
               mw[d] = m_w;
               mv[d] = 1'b1;
            end else if (s_ack[d]) begin
               mv[d] = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("to_nitta32",   b32.to_nitta,   mw[0]);
         chk("word_valid32", {31'h0, b32.word_valid}, {31'h0, mv[0]});
         chk("busy32",       {31'h0, b32.busy},       {31'h0, mn[0] != 0});
         chk("to_nitta16",   {16'h0, b16.to_nitta},   {16'h0, mw[1][15:0]});
         chk("word_valid16", {31'h0, b16.word_valid}, {31'h0, mv[1]});
         chk("busy16",       {31'h0, b16.busy},       {31'h0, mn[1] != 0});
`ifdef SPI_ASSEMBLER_OVERFLOW_EN
         chk("overflow32",   {31'h0, b32.overflow},   {31'h0, mo[0]});
         chk("overflow16",   {31'h0, b16.overflow},   {31'h0, mo[1]});
`endif
      end
   end

   task automatic drive(input int d, input bit rdy, input logic [7:0] v, input bit ack);
      if (d == 0) begin
         b32.spi_ready = rdy; b32.from_spi = v; b32.nitta_ack = ack;
      end else begin
         b16.spi_ready = rdy; b16.from_spi = v; b16.nitta_ack = ack;
      end
      @(posedge clk);
      #1;
      b32.spi_ready = 1'b0; b32.from_spi = 8'h00; b32.nitta_ack = 1'b0;
      b16.spi_ready = 1'b0; b16.from_spi = 8'h00; b16.nitta_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input int d, input logic [7:0] v);
      drive(d, 1'b1, v, 1'b0);
   endtask

   task automatic send_word(input int d, input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) strobe(d, w[8*(n-i)-1 -: 8]);
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      b32.spi_ready = 1'b0; b32.from_spi = 8'h00; b32.nitta_ack = 1'b0;
      b16.spi_ready = 1'b0; b16.from_spi = 8'h00; b16.nitta_ack = 1'b0;
      idle(2);
      cmp_en = 1'b1;
      rst    = 1'b0;
      chk("reset_to_nitta",   b32.to_nitta, 32'h0);
      chk("reset_word_valid", {31'h0, b32.word_valid}, 32'h0);
      chk("reset_busy",       {31'h0, b32.busy}, 32'h0);
`ifdef SPI_ASSEMBLER_OVERFLOW_EN
      chk("reset_overflow",   {31'h0, b32.overflow}, 32'h0);
`endif

      // Gapped strobes
      strobe(0, 8'hAA); idle(3);
      strobe(0, 8'hAB); idle(3);
      strobe(0, 8'hAC); idle(3);
      chk("t1_valid_before_last", {31'h0, b32.word_valid}, 32'h0);
      chk("t1_busy_mid",          {31'h0, b32.busy}, 32'h1);
      strobe(0, 8'hAD);
      chk("t1_word",  b32.to_nitta, 32'hAAABACAD);
      chk("t1_valid", {31'h0, b32.word_valid}, 32'h1);
      chk("t1_busy",  {31'h0, b32.busy}, 32'h0);

      // Back-to-back strobes with an ack landing mid second word
      drive(0, 1'b0, 8'h00, 1'b1);
      chk("t2_ack_clears", {31'h0, b32.word_valid}, 32'h0);
      send_word(0, 32'h01020304, 4);
      chk("t2_word1", b32.to_nitta, 32'h01020304);
      strobe(0, 8'h05);
      drive(0, 1'b1, 8'h06, 1'b1);
      chk("t2_ack_mid",  {31'h0, b32.word_valid}, 32'h0);
      chk("t2_hold",     b32.to_nitta, 32'h01020304);
      strobe(0, 8'h07);
      strobe(0, 8'h08);
      chk("t2_word2",  b32.to_nitta, 32'h05060708);
      chk("t2_revalid", {31'h0, b32.word_valid}, 32'h1);
      drive(0, 1'b0, 8'h00, 1'b1);

      // Reset mid-word drops the partial chunks
      strobe(0, 8'h55);
      chk("t3_busy_after_55", {31'h0, b32.busy}, 32'h1);
      strobe(0, 8'h66);
      reset_cycle();
      chk("t3_busy_after_rst", {31'h0, b32.busy}, 32'h0);
      send_word(0, 32'h11223344, 4);
      chk("t3_word", b32.to_nitta, 32'h11223344);

      // Unacknowledged overwrite
      reset_cycle();
      send_word(0, 32'hDEADBEEF, 4);
      chk("t4_word1", b32.to_nitta, 32'hDEADBEEF);
      send_word(0, 32'hCAFEF00D, 4);
      chk("t4_word2", b32.to_nitta, 32'hCAFEF00D);
      chk("t4_valid", {31'h0, b32.word_valid}, 32'h1);
`ifdef SPI_ASSEMBLER_OVERFLOW_EN
      chk("t4_overflow", {31'h0, b32.overflow}, 32'h1);
      idle(3);
      chk("t4_overflow_sticky", {31'h0, b32.overflow}, 32'h1);
`endif
      reset_cycle();
`ifdef SPI_ASSEMBLER_OVERFLOW_EN
      chk("t4_overflow_cleared", {31'h0, b32.overflow}, 32'h0);
`endif

      // Ack coincident with completion
      send_word(0, 32'h0A0B0C0D, 4);
      strobe(0, 8'h12); strobe(0, 8'h34); strobe(0, 8'h56);
      drive(0, 1'b1, 8'h78, 1'b1);
      chk("t5_word",  b32.to_nitta, 32'h12345678);
      chk("t5_valid", {31'h0, b32.word_valid}, 32'h1);
`ifdef SPI_ASSEMBLER_OVERFLOW_EN
      chk("t5_no_overflow", {31'h0, b32.overflow}, 32'h0);
`endif

      // 16-bit instance
      strobe(1, 8'hBE);
      chk("t6_busy_mid", {31'h0, b16.busy}, 32'h1);
      strobe(1, 8'hEF);
      chk("t6_word",  {16'h0, b16.to_nitta}, 32'h0000BEEF);
      chk("t6_valid", {31'h0, b16.word_valid}, 32'h1);
      chk("t6_busy",  {31'h0, b16.busy}, 32'h0);
      strobe(1, 8'h11);
      chk("t6_busy_third", {31'h0, b16.busy}, 32'h1);
      idle(2);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
